// File: rtl/hyst_window_feeder_pkg.sv
// Shared edge-detector definitions used by the hysteresis window feeder.
//   - neighbour index constants inside a 5-entry window
//   - window type: 5 x 8-bit packed array
//   - decision encoding and bit expansion helper
package hyst_window_feeder_pkg;

   localparam int unsigned NB_CUR   = 4;
   localparam int unsigned NB_W     = 3;
   localparam int unsigned NB_NW    = 2;
   localparam int unsigned NB_N     = 1;
   localparam int unsigned NB_NE    = 0;
   localparam int unsigned NB_COUNT = 5;

   // Only a full-scale result counts as a strong/edge decision.
   localparam logic [7:0] DEC_ON = 8'hFF;

   typedef logic [NB_COUNT-1:0][7:0] win_t;

   function automatic logic [7:0] expand_bit(input logic b);
      return b ? 8'hFF : 8'h00;
   endfunction

endpackage

// File: rtl/hyst_line_buffer.sv
// One-bit-per-pixel decision store spanning a single image row.
// Ports:
//   clk        - clock
//   i_rd_addr  - read column (asynchronous read)
//   o_rd_data  - stored decision bit at i_rd_addr
//   i_wr_en    - write strobe
//   i_wr_addr  - write column
//   i_wr_data  - decision bit to store
// A read and a write to the same address in one cycle returns the old bit.
module hyst_line_buffer #(
   parameter  int unsigned DEPTH = 320,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic [AW-1:0] i_rd_addr,
   output logic          o_rd_data,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic          i_wr_data
);

   // No reset: row-0 masking in the feeder hides stale contents.
   logic [DEPTH-1:0] r_mem;

   assign o_rd_data = r_mem[i_rd_addr];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

endmodule

// File: rtl/hyst_window_feeder.sv
// Hysteresis window feeder: pairs each incoming gradient sample with the
// already-decided W, NW, N and NE neighbour decisions and hands the window
// to the hysteresis decision block, storing each returned decision as a bit.
// Ports:
//   clk, n_rst             - clock, asynchronous active-low reset
//   in_valid/in_ready      - upstream sample handshake
//   in_mag, in_angle       - gradient magnitude and quantized direction
//   win_valid/win_ready    - window handshake to the decision block
//   win_mag, win_angle     - window (current + 4 neighbours) and angle
//   result_pixel           - decision for the presented window
//   frame_done             - one-cycle pulse after the last pixel is decided
module hyst_window_feeder
   import hyst_window_feeder_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 320,
   parameter int unsigned IMG_HEIGHT = 240
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_mag,
   input  logic [1:0] in_angle,
   output logic       win_valid,
   input  logic       win_ready,
   output win_t       win_mag,
   output logic [1:0] win_angle,
   input  logic [7:0] result_pixel,
   output logic       frame_done
);

   localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   logic             r_win_valid;
   win_t             r_win_mag;
   logic [1:0]       r_win_angle;
   logic             r_frame_done;
   // Position of the pixel in the window (or the next one when empty).
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             r_w_bit;   // decision of the last decided pixel
   logic             r_n_bit;   // previous-row bit above the next pixel
   logic             r_nw_bit;  // previous-row bit up-left of the next pixel

   logic             w_win_hs;
   logic             w_accept;
   logic             w_dec_bit;
   logic             w_col_last;
   logic             w_row_last;
   logic [COL_W-1:0] w_next_col;
   logic [ROW_W-1:0] w_next_row;
   logic [COL_W-1:0] w_acc_col;
   logic [ROW_W-1:0] w_acc_row;
   logic             w_acc_col_last;
   logic             w_has_left;
   logic             w_has_up;
   logic [COL_W-1:0] w_rd_addr;
   logic             w_lb_rd;
   logic             w_w_src;
   logic             w_w;
   logic             w_nw;
   logic             w_n;
   logic             w_ne;
   win_t             w_win;

   assign w_win_hs   = r_win_valid & win_ready;
   assign in_ready   = ~r_win_valid | win_ready;
   assign w_accept   = in_valid & in_ready;
   assign w_dec_bit  = (result_pixel == DEC_ON);
   assign w_col_last = (r_col == COL_LAST);
   assign w_row_last = (r_row == ROW_LAST);

   always_comb begin
      w_next_col = r_col + 1'b1;
      w_next_row = r_row;
      if (w_col_last) begin
         w_next_col = '0;
         w_next_row = w_row_last ? '0 : r_row + 1'b1;
      end
   end

   // An accepted sample lands one past the window being consumed this cycle.
   assign w_acc_col      = w_win_hs ? w_next_col : r_col;
   assign w_acc_row      = w_win_hs ? w_next_row : r_row;
   assign w_acc_col_last = (w_acc_col == COL_LAST);
   assign w_has_left     = (w_acc_col != '0);
   assign w_has_up       = (w_acc_row != '0);

   // Single read port: fetch NE (col+1). At the row's last column fetch
   // column 0 instead, which becomes N for the first pixel of the next row.
   assign w_rd_addr = w_acc_col_last ? '0 : w_acc_col + 1'b1;

   hyst_line_buffer #(
      .DEPTH (IMG_WIDTH)
   ) u_line_buffer (
      .clk       (clk),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_lb_rd),
      .i_wr_en   (w_win_hs),
      .i_wr_addr (r_col),
      .i_wr_data (w_dec_bit)
   );

   // Back-to-back: the left neighbour is decided in this very cycle.
   assign w_w_src = w_win_hs ? w_dec_bit : r_w_bit;
   assign w_w     = w_has_left & w_w_src;
   assign w_n     = w_has_up & r_n_bit;
   assign w_nw    = w_has_up & w_has_left & r_nw_bit;
   assign w_ne    = w_has_up & ~w_acc_col_last & w_lb_rd;

   always_comb begin
      w_win         = '0;
      w_win[NB_CUR] = in_mag;
      w_win[NB_W]   = expand_bit(w_w);
      w_win[NB_NW]  = expand_bit(w_nw);
      w_win[NB_N]   = expand_bit(w_n);
      w_win[NB_NE]  = expand_bit(w_ne);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_win_valid  <= 1'b0;
         r_win_mag    <= '0;
         r_win_angle  <= '0;
         r_frame_done <= 1'b0;
         r_col        <= '0;
         r_row        <= '0;
         r_w_bit      <= 1'b0;
         r_n_bit      <= 1'b0;
         r_nw_bit     <= 1'b0;
      end else begin
         r_frame_done <= w_win_hs & w_col_last & w_row_last;
         if (w_win_hs) begin
            r_col   <= w_next_col;
            r_row   <= w_next_row;
            r_w_bit <= w_dec_bit;
         end
         if (w_accept) begin
            r_win_valid <= 1'b1;
            r_win_mag   <= w_win;
            r_win_angle <= in_angle;
            r_nw_bit    <= r_n_bit;
            r_n_bit     <= w_lb_rd;
         end else if (w_win_hs) begin
            r_win_valid <= 1'b0;
         end
      end
   end

   assign win_valid  = r_win_valid;
   assign win_mag    = r_win_mag;
   assign win_angle  = r_win_angle;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hyst_window_feeder.sv
module tb_hyst_window_feeder;
   import hyst_window_feeder_pkg::*;

   localparam int unsigned W = 4;
   localparam int unsigned H = 2;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_mag;
   logic [1:0] in_angle;
   logic       win_valid;
   logic       win_ready;
   win_t       win_mag;
   logic [1:0] win_angle;
   logic [7:0] result_pixel;
   logic       frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hyst_window_feeder #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_mag       (in_mag),
      .in_angle     (in_angle),
      .win_valid    (win_valid),
      .win_ready    (win_ready),
      .win_mag      (win_mag),
      .win_angle    (win_angle),
      .result_pixel (result_pixel),
      .frame_done   (frame_done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [39:0] mkwin(input logic [7:0] m, input bit bw, input bit bnw,
                                         input bit bn, input bit bne);
      return {m, bw ? 8'hFF : 8'h00, bnw ? 8'hFF : 8'h00, bn ? 8'hFF : 8'h00,
              bne ? 8'hFF : 8'h00};
   endfunction

   // Window expected for pixel j of a stream where every decision is FF.
   function automatic logic [39:0] allff_win(input int j, input logic [7:0] m);
      int p = j % (W * H);
      int r = p / W;
      int c = p % W;
      return mkwin(m, c > 0, (r > 0) && (c > 0), r > 0, (r > 0) && (c < W - 1));
   endfunction

   // Reference model for the random phase: decisions per frame position.
   typedef struct packed {
      logic [7:0] mag;
      logic [1:0] ang;
   } samp_t;
   samp_t q[$];
   bit    dec [H][W];
   int    k;

   function automatic logic [39:0] model_win(input logic [7:0] m);
      int r = k / W;
      int c = k % W;
      bit bw  = (c > 0) ? dec[r][(c > 0) ? c - 1 : 0] : 1'b0;
      bit bn  = (r > 0) ? dec[(r > 0) ? r - 1 : 0][c] : 1'b0;
      bit bnw = (r > 0 && c > 0) ? dec[(r > 0) ? r - 1 : 0][(c > 0) ? c - 1 : 0] : 1'b0;
      bit bne = (r > 0 && c < W - 1) ? dec[(r > 0) ? r - 1 : 0][(c < W - 1) ? c + 1 : c]
                                      : 1'b0;
      return mkwin(m, bw, bnw, bn, bne);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [7:0] m, input logic [1:0] a);
      in_valid = 1'b1;
      in_mag   = m;
      in_angle = a;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic decide(input logic [7:0] r);
      win_ready    = 1'b1;
      result_pixel = r;
      tick();
      win_ready = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  mag;
      logic [1:0]  ang;
      logic [7:0]  res;
      logic [39:0] exp;
   } vec_t;
   vec_t tbl [8];

   initial begin
      int    npulse;
      bit    fd_exp;
      bit    hs;
      bit    acc;
      bit    model_ready;

      tbl[0] = '{8'd60, 2'd2, 8'hFF, mkwin(8'd60, 0, 0, 0, 0)};
      tbl[1] = '{8'd21, 2'd1, 8'h7F, mkwin(8'd21, 1, 0, 0, 0)};
      tbl[2] = '{8'd32, 2'd3, 8'hFF, mkwin(8'd32, 0, 0, 0, 0)};
      tbl[3] = '{8'd43, 2'd0, 8'h00, mkwin(8'd43, 1, 0, 0, 0)};
      tbl[4] = '{8'd54, 2'd1, 8'hFF, mkwin(8'd54, 0, 0, 1, 0)};
      tbl[5] = '{8'd65, 2'd2, 8'hFE, mkwin(8'd65, 1, 1, 0, 1)};
      tbl[6] = '{8'd76, 2'd3, 8'hFF, mkwin(8'd76, 0, 0, 1, 0)};
      tbl[7] = '{8'd87, 2'd0, 8'h01, mkwin(8'd87, 1, 1, 0, 0)};

      n_rst        = 1'b0;
      in_valid     = 1'b0;
      in_mag       = '0;
      in_angle     = '0;
      win_ready    = 1'b0;
      result_pixel = '0;
      #1;
      check("reset_win_valid", 64'(win_valid), 64'd0);
      check("reset_win_mag", 64'(win_mag), 64'd0);
      check("reset_win_angle", 64'(win_angle), 64'd0);
      check("reset_frame_done", 64'(frame_done), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      tick();
      tick();
      n_rst = 1'b1;
      tick();

      // Table-driven frame: one pixel at a time, decision returned later.
      for (int i = 0; i < 8; i++) begin
         check($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'd1);
         present(tbl[i].mag, tbl[i].ang);
         check($sformatf("tbl%0d_win_valid", i), 64'(win_valid), 64'd1);
         check($sformatf("tbl%0d_win_mag", i), 64'(win_mag), 64'(tbl[i].exp));
         check($sformatf("tbl%0d_win_angle", i), 64'(win_angle), 64'(tbl[i].ang));
         decide(tbl[i].res);
         check($sformatf("tbl%0d_frame_done", i), 64'(frame_done), 64'(i == 7));
         check($sformatf("tbl%0d_win_empty", i), 64'(win_valid), 64'd0);
      end
      tick();
      check("tbl_frame_done_pulse_end", 64'(frame_done), 64'd0);

      // Stall: window held while the next sample waits upstream.
      present(8'h11, 2'd1);
      in_valid = 1'b1;
      in_mag   = 8'h22;
      in_angle = 2'd2;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall%0d_in_ready", i), 64'(in_ready), 64'd0);
         check($sformatf("stall%0d_win_valid", i), 64'(win_valid), 64'd1);
         check($sformatf("stall%0d_win_mag", i), 64'(win_mag), 64'(mkwin(8'h11, 0, 0, 0, 0)));
         check($sformatf("stall%0d_win_angle", i), 64'(win_angle), 64'd1);
         tick();
      end
      win_ready    = 1'b1;
      result_pixel = 8'hFF;
      #1;
      check("stall_release_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid  = 1'b0;
      win_ready = 1'b0;
      check("stall_next_valid", 64'(win_valid), 64'd1);
      check("stall_next_win_mag", 64'(win_mag), 64'(mkwin(8'h22, 1, 0, 0, 0)));
      check("stall_next_win_angle", 64'(win_angle), 64'd2);
      decide(8'hFF);

      // Advance to pixel (1,2), then reset asynchronously mid-cycle.
      for (int j = 2; j <= 6; j++) begin
         present(8'(j * 16), 2'd0);
         if (j < 6) decide(8'hFF);
      end
      check("pix12_win_mag", 64'(win_mag), 64'(mkwin(8'h60, 1, 1, 1, 1)));
      #3;
      n_rst = 1'b0;
      #1;
      check("async_rst_win_valid", 64'(win_valid), 64'd0);
      check("async_rst_win_mag", 64'(win_mag), 64'd0);
      check("async_rst_win_angle", 64'(win_angle), 64'd0);
      check("async_rst_frame_done", 64'(frame_done), 64'd0);
      check("async_rst_in_ready", 64'(in_ready), 64'd1);
      tick();
      n_rst = 1'b1;
      tick();

      // Two back-to-back all-FF frames starting at (0,0) after the reset.
      npulse = 0;
      for (int i = 0; i < 18; i++) begin
         check($sformatf("b2b%0d_frame_done", i), 64'(frame_done),
               64'((i >= 2) && (((i - 2) % 8) == 7)));
         if (frame_done) npulse++;
         if (i >= 1 && i <= 16) begin
            check($sformatf("b2b%0d_win_valid", i), 64'(win_valid), 64'd1);
            check($sformatf("b2b%0d_win_mag", i), 64'(win_mag),
                  64'(allff_win(i - 1, 8'(100 + i - 1))));
            check($sformatf("b2b%0d_win_angle", i), 64'(win_angle), 64'((i - 1) % 4));
         end
         in_valid     = (i < 16);
         in_mag       = 8'(100 + i);
         in_angle     = 2'(i % 4);
         win_ready    = 1'b1;
         result_pixel = 8'hFF;
         tick();
      end
      check("b2b_pulse_count", 64'(npulse), 64'd2);
      check("b2b_drained", 64'(win_valid), 64'd0);
      in_valid  = 1'b0;
      win_ready = 1'b0;

      // Randomized traffic against the frame-level model.
      k      = 0;
      fd_exp = 1'b0;
      for (int cyc = 0; cyc < 3010; cyc++) begin
         check("rnd_frame_done", 64'(frame_done), 64'(fd_exp));
         fd_exp = 1'b0;
         check("rnd_win_valid", 64'(win_valid), 64'(q.size() != 0));
         if (q.size() != 0) begin
            check("rnd_win_mag", 64'(win_mag), 64'(model_win(q[0].mag)));
            check("rnd_win_angle", 64'(win_angle), 64'(q[0].ang));
         end
         in_valid     = (cyc < 3000) && ($urandom_range(0, 3) != 0);
         in_mag       = 8'($urandom);
         in_angle     = 2'($urandom);
         win_ready    = (cyc >= 3000) || ($urandom_range(0, 2) != 0);
         result_pixel = ($urandom_range(0, 2) != 0) ? 8'hFF : 8'($urandom);
         #1;
         model_ready = (q.size() == 0) || win_ready;
         check("rnd_in_ready", 64'(in_ready), 64'(model_ready));
         hs  = (q.size() != 0) && win_ready;
         acc = in_valid && model_ready;
         if (hs) begin
            dec[k / W][k % W] = (result_pixel == 8'hFF);
            void'(q.pop_front());
            k++;
            if (k == W * H) begin
               k      = 0;
               fd_exp = 1'b1;
            end
         end
         if (acc) q.push_back('{in_mag, in_angle});
         @(posedge clk);
         #1;
      end
      check("rnd_queue_empty", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
